// File: rtl/uart_rx_fifo_if.sv
// Receive-side register interface of uart_rx_fifo: head-of-FIFO view, pop strobe,
// error flags and occupancy. The receiver uses "slave"; a consumer uses "master".
interface uart_rx_fifo_if #(
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                    uart_rx_read;
    logic                    uart_rx_valid;
    logic [PAYLOAD_BITS-1:0] uart_rx_data;
    logic                    uart_rx_parity_err;
    logic                    uart_rx_frame_err;
    logic                    uart_rx_overrun;
    logic                    overrun_clear;
    logic [LW-1:0]           fifo_level;

    modport slave (
        input  uart_rx_read, overrun_clear,
        output uart_rx_valid, uart_rx_data, uart_rx_parity_err,
               uart_rx_frame_err, uart_rx_overrun, fifo_level
    );

    modport master (
        output uart_rx_read, overrun_clear,
        input  uart_rx_valid, uart_rx_data, uart_rx_parity_err,
               uart_rx_frame_err, uart_rx_overrun, fifo_level
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-point majority sampling, start-glitch rejection, optional parity
// and a first-word-fall-through receive FIFO carrying per-entry error flags.
module uart_rx_fifo #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int BIT_RATE      = 9600,
    parameter int PAYLOAD_BITS  = 8,
    parameter int STOP_BITS     = 1,
    parameter int PARITY        = 0,
    parameter int FIFO_DEPTH    = 4,
    parameter int RTS_THRESHOLD = FIFO_DEPTH - 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             uart_rxd,
    output logic             uart_rts,
    uart_rx_fifo_if.slave    rx_if
);
    localparam int CPB = (CLK_HZ + BIT_RATE / 2) / BIT_RATE;
    localparam int MID = CPB / 2;
    localparam int CW  = $clog2(CPB);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int PB  = PAYLOAD_BITS;
    localparam int EW  = PB + 2;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_S0    = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_S1    = CW'(MID);
    localparam logic [CW-1:0] CNT_S2    = CW'(MID + 1);
    localparam logic [3:0]    LAST_BIT  = 4'(PB - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] RTS_LVL   = LW'(RTS_THRESHOLD);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t          state_q, state_d;
    logic            sync_q, rxs_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            samp0_q, samp0_d, samp1_q, samp1_d;
    logic [PB-1:0]   shift_q, shift_d;
    logic [3:0]      bidx_q, bidx_d;
    logic            sidx_q, sidx_d;
    logic            perr_q, perr_d, ferr_q, ferr_d;
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            overrun_q, overrun_d;
    logic            rts_q, rts_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];

    logic            push, do_wr, do_pop, full, bit_v, at_mid, at_end, exp_par;
    logic [EW-1:0]   wr_word, head;

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        samp0_d = (cnt_q == CNT_S0) ? rxs_q : samp0_q;
        samp1_d = (cnt_q == CNT_S1) ? rxs_q : samp1_q;
        shift_d = shift_q;
        bidx_d  = bidx_q;
        sidx_d  = sidx_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        push    = 1'b0;
        bit_v   = maj3(samp0_q, samp1_q, rxs_q);
        at_mid  = (cnt_q == CNT_S2);
        at_end  = (cnt_q == CNT_LAST);
        exp_par = (PARITY == 1) ? ~(^shift_q) : ^shift_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs_q) begin
                    state_d = START;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    bidx_d  = '0;
                    sidx_d  = 1'b0;
                end
            end
            START: begin
                // A start bit that reads high at mid-bit was noise on an idle line
                if (at_mid && bit_v) state_d = IDLE;
                else if (at_end)     state_d = DATA;
            end
            DATA: begin
                if (at_mid) shift_d = {bit_v, shift_q[PB-1:1]};
                if (at_end) begin
                    if (bidx_q == LAST_BIT) state_d = (PARITY != 0) ? PAR : STOP;
                    else                    bidx_d  = bidx_q + 4'd1;
                end
            end
            PAR: begin
                if (at_mid && (bit_v != exp_par)) perr_d = 1'b1;
                if (at_end) state_d = STOP;
            end
            STOP: begin
                // Push at mid of the last stop bit so the next start edge is never missed
                if (at_mid) begin
                    if (!bit_v) ferr_d = 1'b1;
                    if (sidx_q == STOP_LAST) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end
                end
                if (at_end) sidx_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_word   = {ferr_d, perr_q, shift_q};
        full      = (level_q == FULL_LVL);
        do_pop    = rx_if.uart_rx_read && (level_q != '0);
        do_wr     = push && (!full || do_pop);
        wptr_d    = do_wr  ? wptr_q + AW'(1) : wptr_q;
        rptr_d    = do_pop ? rptr_q + AW'(1) : rptr_q;
        level_d   = level_q;
        case ({do_wr, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // A fresh overrun takes priority over a simultaneous clear
        if (push && full && !do_pop)   overrun_d = 1'b1;
        else if (rx_if.overrun_clear)  overrun_d = 1'b0;
        else                           overrun_d = overrun_q;
        rts_d     = (level_q >= RTS_LVL);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            sync_q    <= 1'b1;
            rxs_q     <= 1'b1;
            cnt_q     <= '0;
            samp0_q   <= 1'b1;
            samp1_q   <= 1'b1;
            shift_q   <= '0;
            bidx_q    <= '0;
            sidx_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
            rts_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            sync_q    <= uart_rxd;
            rxs_q     <= sync_q;
            cnt_q     <= cnt_d;
            samp0_q   <= samp0_d;
            samp1_q   <= samp1_d;
            shift_q   <= shift_d;
            bidx_q    <= bidx_d;
            sidx_q    <= sidx_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
            rts_q     <= rts_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= wr_word;
    end

    // Head fields are masked while empty so stale storage never leaks out
    always_comb begin
        head                     = mem_q[rptr_q];
        rx_if.uart_rx_valid      = (level_q != '0);
        rx_if.uart_rx_data       = rx_if.uart_rx_valid ? head[PB-1:0] : '0;
        rx_if.uart_rx_parity_err = rx_if.uart_rx_valid && (PARITY != 0) && head[PB];
        rx_if.uart_rx_frame_err  = rx_if.uart_rx_valid && head[PB+1];
        rx_if.uart_rx_overrun    = overrun_q;
        rx_if.fifo_level         = level_q;
        uart_rts                 = rts_q;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: three instances (8N1 depth 4, 8E1, 8N2) on separate
// RX lines, 10 MHz clock and 1 Mbit/s line so each bit lasts 10 clocks.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic resetn;
    logic rxd_a, rxd_b, rxd_c;
    logic rts_a, rts_b, rts_c;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.PAYLOAD_BITS(8), .FIFO_DEPTH(4)) ifa ();
    uart_rx_fifo_if #(.PAYLOAD_BITS(8), .FIFO_DEPTH(4)) ifb ();
    uart_rx_fifo_if #(.PAYLOAD_BITS(8), .FIFO_DEPTH(4)) ifc ();

    uart_rx_fifo #(.CLK_HZ(10_000_000), .BIT_RATE(1_000_000), .PAYLOAD_BITS(8),
                   .STOP_BITS(1), .PARITY(0), .FIFO_DEPTH(4), .RTS_THRESHOLD(3))
        dut_a (.clk(clk), .resetn(resetn), .uart_rxd(rxd_a), .uart_rts(rts_a), .rx_if(ifa));
    uart_rx_fifo #(.CLK_HZ(10_000_000), .BIT_RATE(1_000_000), .PAYLOAD_BITS(8),
                   .STOP_BITS(1), .PARITY(2), .FIFO_DEPTH(4), .RTS_THRESHOLD(3))
        dut_b (.clk(clk), .resetn(resetn), .uart_rxd(rxd_b), .uart_rts(rts_b), .rx_if(ifb));
    uart_rx_fifo #(.CLK_HZ(10_000_000), .BIT_RATE(1_000_000), .PAYLOAD_BITS(8),
                   .STOP_BITS(2), .PARITY(0), .FIFO_DEPTH(4), .RTS_THRESHOLD(3))
        dut_c (.clk(clk), .resetn(resetn), .uart_rxd(rxd_c), .uart_rts(rts_c), .rx_if(ifc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int ln, input logic v);
        case (ln)
            0:       rxd_a = v;
            1:       rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    // Frame bits LSB first: bit 0 is the start bit
    task automatic send(input int ln, input logic [11:0] bits, input int n,
                        input int spike, input bit pop_end);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            drv(ln, bits[i]);
            if (i == spike) begin
                repeat (5) @(posedge clk); #1 drv(ln, ~bits[i]);
                @(posedge clk); #1 drv(ln, bits[i]);
                repeat (4) @(posedge clk); #1;
            end else if (pop_end && i == n - 1) begin
                repeat (9) @(posedge clk); #1 ifa.uart_rx_read = 1'b1;
                @(posedge clk); #1 ifa.uart_rx_read = 1'b0;
            end else begin
                repeat (10) @(posedge clk); #1;
            end
        end
        drv(ln, 1'b1);
    endtask

    task automatic pop(input int ln);
        @(negedge clk);
        case (ln)
            0:       ifa.uart_rx_read = 1'b1;
            1:       ifb.uart_rx_read = 1'b1;
            default: ifc.uart_rx_read = 1'b1;
        endcase
        @(negedge clk);
        ifa.uart_rx_read = 1'b0;
        ifb.uart_rx_read = 1'b0;
        ifc.uart_rx_read = 1'b0;
    endtask

    function automatic logic [11:0] f8n1(input logic [7:0] d);
        return {3'b111, d, 1'b0};
    endfunction

    initial begin
        resetn = 1'b0;
        rxd_a = 1'b1; rxd_b = 1'b1; rxd_c = 1'b1;
        ifa.uart_rx_read = 1'b0; ifb.uart_rx_read = 1'b0; ifc.uart_rx_read = 1'b0;
        ifa.overrun_clear = 1'b0; ifb.overrun_clear = 1'b0; ifc.overrun_clear = 1'b0;

        repeat (3) @(posedge clk); #1;
        chk("rst_rts", rts_a, 1);
        chk("rst_valid", ifa.uart_rx_valid, 0);
        chk("rst_data", ifa.uart_rx_data, 0);
        chk("rst_perr", ifa.uart_rx_parity_err, 0);
        chk("rst_ferr", ifa.uart_rx_frame_err, 0);
        chk("rst_ovr", ifa.uart_rx_overrun, 0);
        chk("rst_level", ifa.fifo_level, 0);
        chk("rst_rts_b", rts_b, 1);
        chk("rst_rts_c", rts_c, 1);
        @(negedge clk) resetn = 1'b1;
        #1 chk("rts_hold_at_release", rts_a, 1);
        @(negedge clk);
        chk("rts_after_release", rts_a, 0);

        // 8N1 single byte
        send(0, f8n1(8'hA5), 10, -1, 1'b0);
        @(negedge clk);
        chk("n1_valid", ifa.uart_rx_valid, 1);
        chk("n1_data", ifa.uart_rx_data, 8'hA5);
        chk("n1_perr", ifa.uart_rx_parity_err, 0);
        chk("n1_ferr", ifa.uart_rx_frame_err, 0);
        chk("n1_level", ifa.fifo_level, 1);
        pop(0);
        chk("n1_pop_valid", ifa.uart_rx_valid, 0);
        chk("n1_pop_level", ifa.fifo_level, 0);
        chk("n1_pop_data", ifa.uart_rx_data, 0);

        // 8E1: 0x03 has even population so the correct parity bit is 0
        send(1, {2'b11, 1'b0, 8'h03, 1'b0}, 11, -1, 1'b0);
        @(negedge clk);
        chk("e1_ok_data", ifb.uart_rx_data, 8'h03);
        chk("e1_ok_perr", ifb.uart_rx_parity_err, 0);
        pop(1);
        send(1, {2'b11, 1'b1, 8'h03, 1'b0}, 11, -1, 1'b0);
        @(negedge clk);
        chk("e1_bad_data", ifb.uart_rx_data, 8'h03);
        chk("e1_bad_perr", ifb.uart_rx_parity_err, 1);
        pop(1);
        chk("e1_level", ifb.fifo_level, 0);

        // 8N2 with second stop bit low, then a clean frame
        send(2, {1'b1, 1'b0, 1'b1, 8'h5A, 1'b0}, 11, -1, 1'b0);
        @(negedge clk);
        chk("n2_err_data", ifc.uart_rx_data, 8'h5A);
        chk("n2_err_ferr", ifc.uart_rx_frame_err, 1);
        pop(2);
        repeat (20) @(negedge clk);
        chk("n2_no_spurious", ifc.fifo_level, 0);
        send(2, {1'b1, 1'b1, 1'b1, 8'h3C, 1'b0}, 11, -1, 1'b0);
        @(negedge clk);
        chk("n2_ok_data", ifc.uart_rx_data, 8'h3C);
        chk("n2_ok_ferr", ifc.uart_rx_frame_err, 0);
        chk("n2_ok_perr", ifc.uart_rx_parity_err, 0);
        chk("n2_ok_level", ifc.fifo_level, 1);

        // Fill past depth, check RTS lag and overrun
        send(0, f8n1(8'h11), 10, -1, 1'b0);
        send(0, f8n1(8'h12), 10, -1, 1'b0);
        repeat (2) @(negedge clk);
        chk("ovr_rts_lvl2", rts_a, 0);
        send(0, f8n1(8'h13), 10, -1, 1'b0);
        @(negedge clk);
        chk("ovr_level3", ifa.fifo_level, 3);
        chk("ovr_rts_lag", rts_a, 0);
        @(negedge clk);
        chk("ovr_rts_set", rts_a, 1);
        send(0, f8n1(8'h14), 10, -1, 1'b0);
        @(negedge clk);
        chk("ovr_level4", ifa.fifo_level, 4);
        chk("ovr_not_yet", ifa.uart_rx_overrun, 0);
        send(0, f8n1(8'h15), 10, -1, 1'b0);
        @(negedge clk);
        chk("ovr_level_full", ifa.fifo_level, 4);
        chk("ovr_flag", ifa.uart_rx_overrun, 1);
        for (int i = 0; i < 4; i++) begin
            chk("ovr_read_order", ifa.uart_rx_data, 32'h11 + i);
            pop(0);
        end
        chk("ovr_drained", ifa.fifo_level, 0);
        chk("ovr_sticky", ifa.uart_rx_overrun, 1);
        @(negedge clk) ifa.overrun_clear = 1'b1;
        @(negedge clk) ifa.overrun_clear = 1'b0;
        chk("ovr_cleared", ifa.uart_rx_overrun, 0);

        // Push and pop on the same edge while full
        send(0, f8n1(8'h21), 10, -1, 1'b0);
        send(0, f8n1(8'h22), 10, -1, 1'b0);
        send(0, f8n1(8'h23), 10, -1, 1'b0);
        send(0, f8n1(8'h24), 10, -1, 1'b0);
        send(0, f8n1(8'h25), 10, -1, 1'b1);
        @(negedge clk);
        chk("pp_level", ifa.fifo_level, 4);
        chk("pp_no_ovr", ifa.uart_rx_overrun, 0);
        chk("pp_head", ifa.uart_rx_data, 8'h22);
        for (int i = 0; i < 4; i++) begin
            chk("pp_read_order", ifa.uart_rx_data, 32'h22 + i);
            pop(0);
        end
        chk("pp_drained", ifa.uart_rx_valid, 0);

        // Short low pulse while idle
        @(posedge clk); #1 drv(0, 1'b0);
        repeat (3) @(posedge clk); #1 drv(0, 1'b1);
        repeat (30) @(negedge clk);
        chk("glitch_level", ifa.fifo_level, 0);
        chk("glitch_valid", ifa.uart_rx_valid, 0);

        // One-clock high spike inside data bit 2 (a 0 bit of 0x5A)
        send(0, f8n1(8'h5A), 10, 3, 1'b0);
        @(negedge clk);
        chk("spike_data", ifa.uart_rx_data, 8'h5A);
        chk("spike_level", ifa.fifo_level, 1);
        send(0, f8n1(8'h77), 10, -1, 1'b0);
        @(negedge clk);
        chk("pre_rst_level", ifa.fifo_level, 2);

        // Reset during data bit 2 of 0xF8, released while the line is high
        @(posedge clk); #1 drv(0, 1'b0);
        repeat (35) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("mid_rst_level", ifa.fifo_level, 0);
        chk("mid_rst_valid", ifa.uart_rx_valid, 0);
        chk("mid_rst_data", ifa.uart_rx_data, 0);
        chk("mid_rst_rts", rts_a, 1);
        chk("mid_rst_ovr", ifa.uart_rx_overrun, 0);
        repeat (5) @(posedge clk); #1 drv(0, 1'b1);
        @(negedge clk) resetn = 1'b1;
        repeat (80) @(negedge clk);
        chk("post_rst_no_push", ifa.fifo_level, 0);
        chk("post_rst_rts", rts_a, 0);
        send(0, f8n1(8'h3C), 10, -1, 1'b0);
        @(negedge clk);
        chk("post_rst_data", ifa.uart_rx_data, 8'h3C);
        chk("post_rst_level", ifa.fifo_level, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with configurable frame format, optional parity, per-bit majority sampling, start-bit glitch rejection and a receive FIFO with per-entry error flags. It sits between the external RX pin and the peripheral register interface. It drives a level-based, active-low RTS so the sender is throttled before the FIFO overflows.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency in Hz.
- `BIT_RATE`, 9600, line bit rate in bits/s; `CPB = (CLK_HZ + BIT_RATE/2) / BIT_RATE`, `CPB >= 8`.
- `PAYLOAD_BITS`, 8, data bits per frame, 5..9, LSB first.
- `STOP_BITS`, 1, stop bits per frame, 1 or 2.
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even.
- `FIFO_DEPTH`, 4, entries, power of two, >= 2.
- `RTS_THRESHOLD`, FIFO_DEPTH-1, FIFO level at which RTS deasserts, 1..FIFO_DEPTH.
- `clk` in 1 — system clock; everything is synchronous to rising edge.
- `resetn` in 1 — asynchronous, active-low reset.
- `uart_rxd` in 1 — asynchronous RX pin, idle high.
- `uart_rts` out 1 — active-low request to send; 1 = stop sending.
- `uart_rx_read` in 1 — pop the head entry; ignored when FIFO empty.
- `uart_rx_valid` out 1 — FIFO non-empty.
- `uart_rx_data` out PAYLOAD_BITS — head entry data; 0 when empty.
- `uart_rx_parity_err` out 1 — head entry parity error; 0 when empty or `PARITY=0`.
- `uart_rx_frame_err` out 1 — head entry had at least one low stop bit.
- `uart_rx_overrun` out 1 — sticky: a frame was dropped because the FIFO was full.
- `overrun_clear` in 1 — clears `uart_rx_overrun`.
- `fifo_level` out $clog2(FIFO_DEPTH)+1 — current entry count.

## Operation
- **Input synchroniser.** `uart_rxd` passes through a 2-flop synchroniser, reset to 1. All logic uses the synchronised signal `rxs`.
- **Bit counter.** The cycle counter counts 0..CPB-1 and wraps at CPB-1, which marks the bit boundary. `MID = CPB/2`.
- **Majority sampling.** Each bit value is the majority of `rxs` at counts MID-1, MID and MID+1. The value is valid at MID+1.
- **FSM states:** IDLE, START, DATA, PAR, STOP.
  - IDLE -> START on `rxs`==0. The counter is cleared on entry.
  - START: at MID+1, a majority of 1 is a glitch and returns to IDLE with no flags. A majority of 0 continues; at the bit boundary go to DATA.
  - DATA: shift each majority bit in LSB first. After PAYLOAD_BITS boundaries go to PAR if `PARITY!=0`, else STOP.
  - PAR: the received parity bit is checked against XOR(data) (even) or ~XOR(data) (odd). A mismatch latches the parity error.
  - STOP: each stop bit is sampled by majority; any 0 latches the frame error.
    - At MID+1 of the final stop bit, push {frame_err, parity_err, data} and go to IDLE. There is no wait for the bit end, so back-to-back frames resynchronise.
- **FIFO.** Circular buffer with read and write pointers plus a level counter. Read is first-word-fall-through.
  - Push when full: the frame is discarded, `uart_rx_overrun` is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle: both take effect and the level is unchanged, including when full (no overrun).
  - `overrun_clear` in the same cycle as a new overrun: set wins.
- **RTS.** `uart_rts` is registered as `(fifo_level >= RTS_THRESHOLD)`.
- **Reset.** Reset may be asserted at any time, including mid-frame. It immediately returns the FSM to IDLE, empties the FIFO, clears flags, and discards the partial frame.

## Timing
- Reset values:
  - `uart_rts`=1.
  - `uart_rx_valid`, `uart_rx_data`, `uart_rx_parity_err`, `uart_rx_frame_err`, `uart_rx_overrun` = 0.
  - `fifo_level` = 0.
- `uart_rts` first reflects the FIFO level one clock after reset release.
- RX latency: `uart_rx_valid` rises 1 clock after the final stop-bit MID+1 sample. That is about 2 + (1+PAYLOAD_BITS+P+STOP_BITS-1)*CPB + MID+2 clocks after the falling edge on the pin, where P = 1 if `PARITY!=0`, else 0.
- Pop: with `uart_rx_read`=1 on edge N, the next entry (or empty) is visible after edge N.
- `fifo_level` and `uart_rx_overrun` update on the push/pop edge; `uart_rts` follows one clock later.
- A low pulse on `rxs` shorter than MID-1 clocks produces no state change beyond START and no FIFO activity.

## Test plan
All scenarios use CLK_HZ=10_000_000 and BIT_RATE=1_000_000, so CPB=10 and MID=5.
- **8N1 single byte.** Send 0xA5 -> `uart_rx_valid`=1, data 0xA5, both error flags 0, `fifo_level`=1. Pulse read -> valid 0 and level 0 next cycle.
- **Even parity, 8E1.** Send 0x03 with parity bit 0 -> data 0x03, `parity_err`=0. Send 0x03 with parity bit 1 -> `parity_err`=1.
- **Frame error, 8N2.** Send 0x5A with the second stop bit low -> data 0x5A, `frame_err`=1. A following 0x3C is received cleanly with no flags.
- **Overrun and RTS.** Set FIFO_DEPTH=4, RTS_THRESHOLD=3. Send 0x11..0x15 with no reads:
  - `uart_rts` goes 1 after the 3rd push.
  - Level stays 4 and `uart_rx_overrun`=1.
  - Reads return 0x11..0x14 in order.
  - `overrun_clear` -> overrun 0.
  - Also check push+pop on the same edge while full -> level 4, no overrun.
- **Glitch rejection.** Drive `uart_rxd` low for 3 clocks while idle -> no push and level 0. A single 1-clock-high spike mid data bit is ignored by majority sampling, and the byte is received correctly.
- **Reset mid-frame.** Assert `resetn`=0 during DATA with 2 entries queued -> all outputs at reset values asynchronously. After release, the rest of the frame on the line produces no push unless a valid start bit is seen.
